// File: rtl/wbuffer_param.sv
// wbuffer_param: write-back line buffer between the dcache and the AXI3 write channels.
// Define WBUF_BYTE_MERGE_EN to add per-byte strobes (wdata_strb) and stored byte masks.
module wbuffer_param #(
   parameter int DEPTH        = 8,
   parameter int LINE_WORDS   = 8,
   parameter int DRAIN_THRESH = 4,
   parameter int AXI_ID       = 0,
   localparam int PTR_W       = $clog2(DEPTH),
   localparam int CNT_W       = PTR_W + 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wreq,
   output logic                     wreq_recvd,
   input  logic [31:0]              wdata_paddr,
   input  logic [32*LINE_WORDS-1:0] wdata_line,
`ifdef WBUF_BYTE_MERGE_EN
   input  logic [4*LINE_WORDS-1:0]  wdata_strb,
`endif
   input  logic [31:0]              lookup_paddr,
   output logic                     lookup_hit,
   output logic [32*LINE_WORDS-1:0] lookup_data,
   input  logic                     clear,
   output logic                     clear_done,
   output logic                     empty,
   output logic                     full,
   output logic                     bus_err,
   output logic [3:0]               awid,
   output logic [31:0]              awaddr,
   output logic [3:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [3:0]               wid,
   output logic [31:0]              wdata,
   output logic [3:0]               wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [3:0]               bid,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   output logic [1:0]               drain_state,
   output logic [CNT_W-1:0]         dbg_count
);

   localparam int OFF       = $clog2(4*LINE_WORDS);
   localparam int TAG_W     = 32 - OFF;
   localparam int LINE_BITS = 32*LINE_WORDS;
   localparam int BEAT_W    = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_AW = 2'd1, S_W = 2'd2, S_B = 2'd3} state_t;

   state_t                 state_q, state_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic [TAG_W-1:0]       tag_q  [DEPTH];
   logic [TAG_W-1:0]       tag_d  [DEPTH];
   logic [LINE_BITS-1:0]   data_q [DEPTH];
   logic [LINE_BITS-1:0]   data_d [DEPTH];
   logic [DEPTH-1:0]       valid_q, valid_d;
   logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   clear_pend_q, clear_pend_d;
   logic                   bus_err_q, bus_err_d;
`ifdef WBUF_BYTE_MERGE_EN
   logic [4*LINE_WORDS-1:0] mask_q [DEPTH];
   logic [4*LINE_WORDS-1:0] mask_d [DEPTH];
   logic [LINE_BITS-1:0]    strb_bits;
`endif

   logic [DEPTH-1:0] lk_hit_vec, wr_hit_vec;
   logic [PTR_W-1:0] wr_hit_idx;
   logic             wr_hit, draining, retire, blocked;
   logic             accept_new, accept_hit, drain_go, last_beat;
   logic             unused_bits;

   assign unused_bits = ^{bid, wdata_paddr[OFF-1:0], lookup_paddr[OFF-1:0]};

   // Tags are unique among valid entries, so OR-ing the matches yields the single hit.
   always_comb begin
      lk_hit_vec  = '0;
      wr_hit_vec  = '0;
      lookup_data = '0;
      wr_hit_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_paddr[31:OFF]);
         wr_hit_vec[i] = valid_q[i] && (tag_q[i] == wdata_paddr[31:OFF]);
         if (lk_hit_vec[i]) lookup_data = lookup_data | data_q[i];
         if (wr_hit_vec[i]) wr_hit_idx  = wr_hit_idx | PTR_W'(i);
      end
   end

   assign lookup_hit = |lk_hit_vec;
   assign wr_hit     = |wr_hit_vec;
   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign draining   = (state_q != S_IDLE);
   assign retire     = (state_q == S_B) && bvalid;
   assign blocked    = (full && !wr_hit && !retire) || (wr_hit && draining && (wr_hit_idx == head_q));
   assign wreq_recvd = wreq && !blocked;
   assign accept_new = wreq_recvd && !wr_hit;
   assign accept_hit = wreq_recvd && wr_hit;
   assign clear_done = clear_pend_q && empty && !accept_new;
   assign last_beat  = (beat_q == BEAT_W'(LINE_WORDS-1));
   assign drain_go   = (count_d >= CNT_W'(DRAIN_THRESH)) || (clear_pend_q && !empty);
   assign bus_err    = bus_err_q;
   assign dbg_count  = count_q;
   assign drain_state = state_q;

`ifdef WBUF_BYTE_MERGE_EN
   always_comb begin
      strb_bits = '0;
      for (int b = 0; b < 4*LINE_WORDS; b++) strb_bits[8*b +: 8] = {8{wdata_strb[b]}};
   end
`endif

   // Retire clears the head slot first so a coinciding accept into that slot wins.
   always_comb begin
      tag_d   = tag_q;
      data_d  = data_q;
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
`ifdef WBUF_BYTE_MERGE_EN
      mask_d  = mask_q;
`endif
      if (retire) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (accept_hit) begin
`ifdef WBUF_BYTE_MERGE_EN
         data_d[wr_hit_idx] = (data_q[wr_hit_idx] & ~strb_bits) | (wdata_line & strb_bits);
         mask_d[wr_hit_idx] = mask_q[wr_hit_idx] | wdata_strb;
`else
         data_d[wr_hit_idx] = wdata_line;
`endif
      end
      if (accept_new) begin
         tag_d[tail_q]   = wdata_paddr[31:OFF];
         data_d[tail_q]  = wdata_line;
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
`ifdef WBUF_BYTE_MERGE_EN
         mask_d[tail_q]  = wdata_strb;
`endif
      end
      case ({accept_new, retire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      clear_pend_d = (clear_pend_q && !clear_done) || clear;
      bus_err_d    = bus_err_q || (retire && (bresp != 2'b00));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
`ifdef WBUF_BYTE_MERGE_EN
            mask_q[i] <= '0;
`endif
         end
         valid_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         clear_pend_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         tag_q        <= tag_d;
         data_q       <= data_d;
`ifdef WBUF_BYTE_MERGE_EN
         mask_q       <= mask_d;
`endif
         valid_q      <= valid_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         clear_pend_q <= clear_pend_d;
         bus_err_q    <= bus_err_d;
      end
   end

   // Drain FSM: state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // AXI channels: a transfer happens on a cycle where valid and ready are both high;
   // once valid rises it stays high with a stable payload until that cycle.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: if (drain_go) state_d = S_AW;
         S_AW: begin
            if (awready) begin
               state_d = S_W;
               beat_d  = '0;
            end
         end
         S_W: begin
            if (wready) begin
               if (last_beat) state_d = S_B;
               else           beat_d  = beat_q + 1'b1;
            end
         end
         S_B:     if (bvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      awid    = 4'(AXI_ID);
      wid     = 4'(AXI_ID);
      awsize  = 3'b010;
      awburst = 2'b01;
      awlen   = 4'(LINE_WORDS-1);
      awaddr  = {tag_q[head_q], {OFF{1'b0}}};
      awvalid = (state_q == S_AW);
      wvalid  = (state_q == S_W);
      wlast   = (state_q == S_W) && last_beat;
      wdata   = data_q[head_q][32*beat_q +: 32];
      bready  = (state_q == S_B);
`ifdef WBUF_BYTE_MERGE_EN
      wstrb   = mask_q[head_q][4*beat_q +: 4];
`else
      wstrb   = 4'hF;
`endif
   end

endmodule

// File: tb/tb_wbuffer_param.sv
// Directed bench for wbuffer_param: AXI slave model, AW/W scoreboard monitor, directed checks.
`timescale 1ns/1ps
module tb_wbuffer_param;
  localparam int LW = 8;
  localparam int LB = 32*LW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic wreq = 1'b0;
  logic wreq_recvd;
  logic [31:0] wdata_paddr = '0;
  logic [LB-1:0] wdata_line = '0;
  logic [4*LW-1:0] wdata_strb = '1;
  logic [31:0] lookup_paddr = '0;
  logic lookup_hit;
  logic [LB-1:0] lookup_data;
  logic clear = 1'b0;
  logic clear_done, empty, full, bus_err;
  logic [3:0] awid, awlen, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0] drain_state;
  logic [3:0] dbg_count;

  int n_checks = 0;
  int n_pass = 0;
  int b_total = 0;
  int err_at = -1;
  bit aw_allow = 1'b1;
  logic [35:0] exp_aw_q[$];
  logic [36:0] exp_w_q[$];

  wbuffer_param #(.DEPTH(8), .LINE_WORDS(LW), .DRAIN_THRESH(4), .AXI_ID(0)) dut (
    .clk(clk), .rstn(rstn), .wreq(wreq), .wreq_recvd(wreq_recvd),
    .wdata_paddr(wdata_paddr), .wdata_line(wdata_line),
`ifdef WBUF_BYTE_MERGE_EN
    .wdata_strb(wdata_strb),
`endif
    .lookup_paddr(lookup_paddr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .clear(clear), .clear_done(clear_done), .empty(empty), .full(full), .bus_err(bus_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .drain_state(drain_state), .dbg_count(dbg_count)
  );

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LB-1:0] make_line(input logic [31:0] a, input logic [7:0] salt);
    logic [LB-1:0] l;
    for (int k = 0; k < LW; k++) l[32*k +: 32] = {salt, a[15:0], 8'(k)};
    return l;
  endfunction

  task automatic push_burst(input logic [31:0] a, input logic [LB-1:0] l, input logic [4*LW-1:0] m);
    exp_aw_q.push_back({4'(LW-1), a});
    for (int k = 0; k < LW; k++) exp_w_q.push_back({(k == LW-1), m[4*k +: 4], l[32*k +: 32]});
  endtask

  // Holds wreq until accepted or max_wait stalled cycles elapse; reports B handshakes around the accept.
  task automatic do_write(input logic [31:0] a, input logic [LB-1:0] l, input logic [4*LW-1:0] s,
                          input int max_wait, output bit acc, output int waited,
                          output bit bhs_at, output bit bhs_prev);
    bit prev;
    wdata_paddr = a; wdata_line = l; wdata_strb = s; wreq = 1'b1;
    acc = 1'b0; waited = 0; bhs_at = 1'b0; bhs_prev = 1'b0; prev = 1'b0;
    while (!acc && waited <= max_wait) begin
      @(negedge clk);
      if (wreq_recvd) begin
        acc = 1'b1; bhs_at = bvalid && bready; bhs_prev = prev;
      end else begin
        prev = bvalid && bready; waited++;
      end
      tick();
    end
    wreq = 1'b0;
  endtask

  task automatic wait_bhs(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = bvalid && bready;
      tick();
    end
  endtask

  task automatic wait_settle(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = (drain_state == 2'd0) && (dbg_count == 4'(n)) && !awvalid;
      tick();
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // AXI slave: awready follows aw_allow, wready always high, B one cycle after the last W beat.
  initial begin : axi_slave
    bit last_hs, b_hs, pend;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0; pend = 1'b0;
    forever begin
      @(negedge clk);
      last_hs = wvalid && wready && wlast;
      b_hs = bvalid && bready;
      @(posedge clk);
      #1;
      awready = aw_allow;
      if (b_hs) begin
        bvalid = 1'b0; bresp = 2'b00; b_total++;
      end
      if (last_hs) pend = 1'b1;
      if (pend && !bvalid) begin
        bvalid = 1'b1;
        bresp = (b_total == err_at) ? 2'b10 : 2'b00;
        pend = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn && awvalid && awready) begin
        if (exp_aw_q.size() == 0) check("aw_unexpected", {awlen, awaddr}, '0);
        else check("aw_addr_len", {awlen, awaddr}, exp_aw_q.pop_front());
        check("aw_attr", {awid, awsize, awburst}, {4'd0, 3'b010, 2'b01});
      end
      if (rstn && wvalid && wready) begin
        if (exp_w_q.size() == 0) check("w_unexpected", {wlast, wstrb, wdata}, '0);
        else check("w_beat", {wid, wlast, wstrb, wdata}, {4'd0, exp_w_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc, bhs_at, bhs_prev, ok;
    int waited;
    logic [LB-1:0] x_line, y_line, exp_line;
    logic [4*LW-1:0] exp_mask;

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rst_flags", {empty, full, awvalid, wvalid, bready, clear_done, bus_err, lookup_hit, wreq_recvd},
          9'b1_0000_0000);
    check("rst_count", dbg_count, 0);
    check("rst_state", drain_state, 0);
    tick();

    // Three lines below the drain threshold.
    do_write(32'h1000, make_line(32'h1000, 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("wr0_acc", acc, 1);
    do_write(32'h1020, make_line(32'h1020, 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("wr1_acc", acc, 1);
    do_write(32'h1040, make_line(32'h1040, 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("wr2_acc", acc, 1);
    lookup_paddr = 32'h1028;
    repeat (2) tick();
    @(negedge clk);
    check("three_count", dbg_count, 3);
    check("three_no_aw", {awvalid, drain_state}, 0);
    check("lk_1020_hit", lookup_hit, 1);
    check("lk_1020_data", lookup_data, make_line(32'h1020, 8'h11));
    tick();
    lookup_paddr = 32'h2000;
    @(negedge clk);
    check("lk_miss", {lookup_hit, lookup_data}, 0);
    tick();

    // Fourth line reaches the threshold and drains the oldest entry.
    push_burst(32'h1000, make_line(32'h1000, 8'h11), '1);
    do_write(32'h1060, make_line(32'h1060, 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("wr3_acc", acc, 1);
    @(negedge clk);
    check("aw_next_cycle", {awvalid, awlen, awaddr}, {1'b1, 4'd7, 32'h1000});
    tick();
    wait_bhs(60, ok);
    check("b1_seen", ok, 1);
    lookup_paddr = 32'h1000;
    @(negedge clk);
    check("lk_1000_retired", lookup_hit, 0);
    check("after_drain_count", dbg_count, 3);
    tick();

    // Fill the buffer while AW is stalled.
    aw_allow = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      do_write(32'h1080 + 32'(32*i), make_line(32'h1080 + 32'(32*i), 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
      check("fill_acc", acc, 1);
    end
    @(negedge clk);
    check("full_flags", {full, empty, awvalid, dbg_count}, {1'b1, 1'b0, 1'b1, 4'd8});
    check("stalled_aw_addr", awaddr, 32'h1020);
    tick();
    do_write(32'h1040, make_line(32'h1040, 8'h22), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("rewrite_nonhead_acc", acc, 1);
    lookup_paddr = 32'h1040;
    @(negedge clk);
    check("rewrite_count", dbg_count, 8);
    check("rewrite_data", lookup_data, make_line(32'h1040, 8'h22));
    tick();
    do_write(32'h1120, make_line(32'h1120, 8'h11), '1, 5, acc, waited, bhs_at, bhs_prev);
    check("full_blocks_new", acc, 0);

    push_burst(32'h1020, make_line(32'h1020, 8'h11), '1);
    push_burst(32'h1040, make_line(32'h1040, 8'h22), '1);
    for (int i = 0; i < 4; i++)
      push_burst(32'h1060 + 32'(32*i), make_line(32'h1060 + 32'(32*i), 8'h11), '1);
    aw_allow = 1'b1;
    do_write(32'h1120, make_line(32'h1120, 8'h11), '1, 80, acc, waited, bhs_at, bhs_prev);
    check("full_accept_on_retire", {acc, bhs_at}, 2'b11);
    wait_settle(3, 400, ok);
    check("settle_to_3", ok, 1);
    lookup_paddr = 32'h1100;
    @(negedge clk);
    check("lk_1100_kept", lookup_hit, 1);
    check("queues_drained", exp_aw_q.size() + exp_w_q.size(), 0);
    tick();

    // Rewrite of the head line while it is in its W phase.
    push_burst(32'h10E0, make_line(32'h10E0, 8'h11), '1);
    push_burst(32'h1100, make_line(32'h1100, 8'h11), '1);
    do_write(32'h1140, make_line(32'h1140, 8'h11), '1, 0, acc, waited, bhs_at, bhs_prev);
    check("wr_1140_acc", acc, 1);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = wvalid;
      tick();
    end
    check("head_w_started", ok, 1);
    do_write(32'h10E0, make_line(32'h10E0, 8'h33), '1, 60, acc, waited, bhs_at, bhs_prev);
    check("head_rewrite_after_b", {acc, bhs_prev, bhs_at}, 3'b110);
    check("head_rewrite_stalled", (waited >= 2), 1);
    wait_settle(3, 200, ok);
    check("settle_after_head", ok, 1);
    lookup_paddr = 32'h10E0;
    @(negedge clk);
    check("head_new_data", {lookup_hit, lookup_data}, {1'b1, make_line(32'h10E0, 8'h33)});
    tick();

    // Clear with two entries, first B response is SLVERR.
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    check("rst2_flags", {empty, bus_err, dbg_count}, {1'b1, 1'b0, 4'd0});
    tick();
    do_write(32'h2000, make_line(32'h2000, 8'h44), '1, 0, acc, waited, bhs_at, bhs_prev);
    do_write(32'h2020, make_line(32'h2020, 8'h44), '1, 0, acc, waited, bhs_at, bhs_prev);
    push_burst(32'h2000, make_line(32'h2000, 8'h44), '1);
    push_burst(32'h2020, make_line(32'h2020, 8'h44), '1);
    err_at = b_total;
    pulse_clear();
    wait_bhs(80, ok);
    check("clr_b1", ok, 1);
    @(negedge clk);
    check("clr_mid", {bus_err, clear_done, empty}, 3'b100);
    tick();
    wait_bhs(80, ok);
    check("clr_b2", ok, 1);
    @(negedge clk);
    check("clr_done_pulse", {clear_done, empty}, 2'b11);
    tick();
    @(negedge clk);
    check("clr_done_one_cycle", {clear_done, bus_err}, 2'b01);
    tick();

    // Clear while already empty.
    clear = 1'b1;
    @(negedge clk);
    check("clr_empty_t0", clear_done, 0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("clr_empty_t1", clear_done, 1);
    tick();
    @(negedge clk);
    check("clr_empty_t2", clear_done, 0);
    tick();

    // Rewrite with partial strobes, then drain it.
    x_line = make_line(32'h3000, 8'h55);
    y_line = make_line(32'h3000, 8'h66);
    do_write(32'h3000, x_line, 32'h0000_000F, 0, acc, waited, bhs_at, bhs_prev);
    do_write(32'h3000, y_line, 32'h0000_00F0, 0, acc, waited, bhs_at, bhs_prev);
    check("merge_rewrite_acc", acc, 1);
`ifdef WBUF_BYTE_MERGE_EN
    exp_line = x_line;
    exp_line[63:32] = y_line[63:32];
    exp_mask = 32'h0000_00FF;
`else
    exp_line = y_line;
    exp_mask = '1;
`endif
    lookup_paddr = 32'h3000;
    @(negedge clk);
    check("merge_count", dbg_count, 1);
    check("merge_lookup", lookup_data, exp_line);
    tick();
    push_burst(32'h3000, exp_line, exp_mask);
    pulse_clear();
    wait_bhs(80, ok);
    check("merge_b", ok, 1);
    @(negedge clk);
    check("merge_clear_done", {clear_done, empty, bus_err}, 3'b111);
    check("final_queues", exp_aw_q.size() + exp_w_q.size(), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
